// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared state encoding and sizing helper for the
// sequential shift-add multiplier.
package multiplier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int MIN_BITS = 2;

   function automatic int mult_count_bits(input int bits);
      return $clog2(bits) + 1;
   endfunction

endpackage

// File: rtl/multiplier_addsub.sv
// multiplier_addsub: W-bit adder/subtractor used for one partial-product
// step of the shift-add multiplier.
module multiplier_addsub
   import multiplier_pkg::*;
#(
   parameter int W = 5
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_sub,
   output logic [W-1:0] o_sum
);

   logic [W-1:0] w_b_inv;

   // Subtraction is a + ~b + 1, sharing one carry chain with addition.
   assign w_b_inv = i_sub ? ~i_b : i_b;
   assign o_sum   = i_a + w_b_inv + W'(i_sub);

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: BITS x BITS sequential shift-add multiplier, signed or
// unsigned at runtime. SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN enables early finish.
module shift_add_multiplier
   import multiplier_pkg::*;
#(
   parameter int BITS = 4
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_signed,
   input  logic [BITS-1:0]   i_multiplicand,
   input  logic [BITS-1:0]   i_multiplier,
   output logic [2*BITS-1:0] o_product,
   output logic              o_busy,
   output logic              o_finished
);

   localparam int COUNT_BITS = mult_count_bits(BITS);
   localparam int AW         = 2 * BITS + 1;

   state_t                r_state;
   logic [AW-1:0]         r_acc;
   logic [BITS-1:0]       r_a;
   logic [BITS-1:0]       r_mplr;
   logic                  r_signed;
   logic [COUNT_BITS-1:0] r_count;

   logic [BITS:0]         w_a_ext;
   logic [BITS:0]         w_addend;
   logic [BITS:0]         w_sum;
   logic                  w_last;
   logic                  w_sub;
   logic                  w_fill;
   logic [AW-1:0]         w_step;
   logic [AW-1:0]         w_next_acc;
   logic [BITS-1:0]       w_mplr_nxt;
   logic                  w_finish;

   assign w_a_ext    = r_signed ? {r_a[BITS-1], r_a} : {1'b0, r_a};
   assign w_last     = (r_count == COUNT_BITS'(BITS - 1));
   // The multiplier MSB carries weight -2^(BITS-1) in signed mode.
   assign w_sub      = r_signed & w_last & r_acc[0];
   assign w_addend   = r_acc[0] ? w_a_ext : '0;
   assign w_mplr_nxt = r_mplr >> 1;

   multiplier_addsub #(
      .W (BITS + 1)
   ) u_addsub (
      .i_a   (r_acc[AW-1:BITS]),
      .i_b   (w_addend),
      .i_sub (w_sub),
      .o_sum (w_sum)
   );

   assign w_fill = r_signed & w_sum[BITS];
   assign w_step = {w_fill, w_sum, r_acc[BITS-1:1]};

`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
   logic                  r_bneg;
   logic [COUNT_BITS-1:0] w_shamt;
   logic [AW-1:0]         w_shr;
   logic                  w_early;

   // Unsigned accumulators have a zero top bit, so one arithmetic shifter
   // serves both modes.
   assign w_shamt    = COUNT_BITS'(BITS - 1) - r_count;
   assign w_shr      = $unsigned($signed(w_step) >>> w_shamt);
   assign w_early    = ~r_bneg & (w_mplr_nxt == '0);
   assign w_next_acc = w_early ? w_shr : w_step;
   assign w_finish   = w_early | w_last;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_bneg <= 1'b0;
      end else if ((r_state != RUN) && i_start) begin
         r_bneg <= i_signed & i_multiplier[BITS-1];
      end
   end
`else
   assign w_next_acc = w_step;
   assign w_finish   = w_last;
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_acc      <= '0;
         r_a        <= '0;
         r_mplr     <= '0;
         r_signed   <= 1'b0;
         r_count    <= '0;
         o_product  <= '0;
         o_busy     <= 1'b0;
         o_finished <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               o_finished <= 1'b0;
               if (i_start) begin
                  r_acc    <= {{(BITS + 1){1'b0}}, i_multiplier};
                  r_a      <= i_multiplicand;
                  r_mplr   <= i_multiplier;
                  r_signed <= i_signed;
                  r_count  <= '0;
                  o_busy   <= 1'b1;
                  r_state  <= RUN;
               end else begin
                  r_state  <= IDLE;
               end
            end
            RUN: begin
               r_acc   <= w_next_acc;
               r_mplr  <= w_mplr_nxt;
               r_count <= r_count + COUNT_BITS'(1);
               if (w_finish) begin
                  o_product  <= w_next_acc[2*BITS-1:0];
                  o_busy     <= 1'b0;
                  o_finished <= 1'b1;
                  r_state    <= DONE;
               end
            end
            default: begin
               o_busy     <= 1'b0;
               o_finished <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

endmodule
